fifo_wr_arbiter: RTL and testbench

// - Shares the write port of one fully-sync FWFT fifo among N requesters using round-robin arbitration.
// - Each requester uses a valid/ready handshake; one word is written per cycle when the fifo is not full.
// - Also sequences fifo flushes: drives the fifo's sync clr (the fifo is built with CLEAR="sync").
// - Sits between peripheral producers (e.g. uart/spi rx paths) and a shared fifo feeding the bus side.

---
 rtl/fifo_wr_arbiter.sv | 136 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the write port of one FWFT fifo among N
// valid/ready requesters with round-robin priority, and sequences
// single-cycle sync clears of that fifo.
// Optional feature macro ARB_BURST_EN: keeps the grant on one requester
// for up to BURST consecutive words while it stays valid.
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N-1:0]       req_vld,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       req_rdy,
  input  logic               flush_req,
  output logic               flush_busy,
  input  logic               fifo_full,
  output logic [WIDTH-1:0]   fifo_din,
  output logic               fifo_w,
  output logic               fifo_clr
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            grantFound;
  logic [PW-1:0]   grantIdx;

  // Reject nonsensical configurations at elaboration time.
  if (N < 1 || BURST < 1) begin : gBadParams
    $error("fifo_wr_arbiter: N and BURST must both be >= 1");
  end

  // Increment a requester index, wrapping at N-1 so N need not be a power of 2.
  function automatic logic [PW-1:0] wrapInc(input logic [PW-1:0] p);
    if (p == PW'(N - 1)) return '0;
    else                 return p + 1'b1;
  endfunction

  // Round-robin search: first valid requester starting at ptr and wrapping.
  always_comb begin
    logic [PW-1:0] idx;
    grantFound = 1'b0;
    grantIdx   = '0;
    idx        = ptr_q;
    for (int k = 0; k < N; k++) begin
      if (!grantFound && req_vld[idx]) begin
        grantFound = 1'b1;
        grantIdx   = idx;
      end
      idx = wrapInc(idx);
    end
  end

  // Flush FSM next state and write-port outputs; outputs are forced idle while in reset.
  always_comb begin
    state_d    = state_q;
    req_rdy    = '0;
    fifo_w     = 1'b0;
    fifo_clr   = 1'b0;
    flush_busy = 1'b0;
    fifo_din   = req_data[int'(grantIdx)*WIDTH +: WIDTH];
    case (state_q)
      IDLE: begin
        fifo_w = rstn & grantFound & ~fifo_full;
        if (fifo_w) req_rdy[grantIdx] = 1'b1;
        if (flush_req) state_d = FLUSH;
      end
      FLUSH: begin
        fifo_clr   = rstn;
        flush_busy = rstn;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ARB_BURST_EN
  localparam int CW = $clog2(BURST + 1);

  logic [CW-1:0] cnt_q, cnt_d, cntNext;

  // Burst lock: ptr parks on the granted requester until BURST words or it goes idle.
  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    cntNext = (grantIdx == ptr_q) ? cnt_q + 1'b1 : CW'(1);
    if (state_q == FLUSH) begin
      if (cnt_q != '0) ptr_d = wrapInc(ptr_q);
      cnt_d = '0;
    end else if (fifo_w) begin
      if (cntNext >= CW'(BURST)) begin
        ptr_d = wrapInc(grantIdx);
        cnt_d = '0;
      end else begin
        ptr_d = grantIdx;
        cnt_d = cntNext;
      end
    end else if (cnt_q != '0 && !req_vld[ptr_q]) begin
      ptr_d = wrapInc(ptr_q);
      cnt_d = '0;
    end
  end

  // Burst counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  // Plain rotation: priority moves past the requester that just wrote.
  always_comb begin
    ptr_d = ptr_q;
    if (fifo_w) ptr_d = wrapInc(grantIdx);
  end
`endif

  // State and priority pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (N=4, WIDTH=8, BURST=4).
// Vector expectations follow ARB_BURST_EN when it is defined.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  req_vld;
  logic [31:0] req_data;
  logic [3:0]  req_rdy;
  logic        flush_req;
  logic        flush_busy;
  logic        fifo_full;
  logic [7:0]  fifo_din;
  logic        fifo_w;
  logic        fifo_clr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] vld;
    logic       flush;
    logic       full;
    logic       expW;
    logic       expClr;
    logic [3:0] expRdy;
    logic [7:0] expDin;
  } vec_t;

  vec_t vecs[$];
  vec_t sbq[$];

  fifo_wr_arbiter #(.N(4), .WIDTH(8), .BURST(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_vld    (req_vld),
    .req_data   (req_data),
    .req_rdy    (req_rdy),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .fifo_full  (fifo_full),
    .fifo_din   (fifo_din),
    .fifo_w     (fifo_w),
    .fifo_clr   (fifo_clr)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] vld, input logic flush, input logic full,
                              input logic w, input logic clr, input logic [3:0] rdy,
                              input logic [7:0] din);
    vec_t v;
    v.vld = vld; v.flush = flush; v.full = full;
    v.expW = w; v.expClr = clr; v.expRdy = rdy; v.expDin = din;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one vector just after the falling edge and queue its expectation.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    req_vld   = v.vld;
    flush_req = v.flush;
    fifo_full = v.full;
    sbq.push_back(v);
  endtask

  // Sample outputs mid low-phase and compare against the oldest expectation.
  task automatic checkOutput(input int idx);
    vec_t e;
    #2;
    if (sbq.size() == 0) begin
      checkVal($sformatf("vec%0d_sb_empty", idx), 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      checkVal($sformatf("vec%0d_w", idx),    {31'd0, fifo_w},     {31'd0, e.expW});
      checkVal($sformatf("vec%0d_clr", idx),  {31'd0, fifo_clr},   {31'd0, e.expClr});
      checkVal($sformatf("vec%0d_busy", idx), {31'd0, flush_busy}, {31'd0, e.expClr});
      checkVal($sformatf("vec%0d_rdy", idx),  {28'd0, req_rdy},    {28'd0, e.expRdy});
      if (e.expW) checkVal($sformatf("vec%0d_din", idx), {24'd0, fifo_din}, {24'd0, e.expDin});
    end
  endtask

  initial begin
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_vld   = 4'b1111;
    flush_req = 1'b0;
    fifo_full = 1'b0;
    rstn      = 1'b0;

`ifdef ARB_BURST_EN
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(4'b1111, 0, 0, 1, 0, 4'(1 << (i / 4)), 8'hA0 + 8'(i / 4)));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(4'b0011, 0, 0, 1, 0, 4'(1 << (i / 4)), 8'hA0 + 8'(i / 4)));
    vecs.push_back(mk(4'b0011, 0, 0, 1, 0, 4'b0001, 8'hA0));
    vecs.push_back(mk(4'b0011, 0, 0, 1, 0, 4'b0001, 8'hA0));
    vecs.push_back(mk(4'b0010, 0, 0, 1, 0, 4'b0010, 8'hA1));
    vecs.push_back(mk(4'b0011, 0, 0, 1, 0, 4'b0010, 8'hA1));
    vecs.push_back(mk(4'b0011, 1, 0, 1, 0, 4'b0010, 8'hA1));
    vecs.push_back(mk(4'b0011, 1, 0, 0, 1, 4'b0000, 8'h00));
    vecs.push_back(mk(4'b0011, 0, 0, 1, 0, 4'b0001, 8'hA0));
    vecs.push_back(mk(4'b0011, 0, 1, 0, 0, 4'b0000, 8'h00));
    vecs.push_back(mk(4'b0011, 0, 1, 0, 0, 4'b0000, 8'h00));
    vecs.push_back(mk(4'b0011, 0, 0, 1, 0, 4'b0001, 8'hA0));
    vecs.push_back(mk(4'b0011, 0, 0, 1, 0, 4'b0001, 8'hA0));
    vecs.push_back(mk(4'b0011, 0, 0, 1, 0, 4'b0001, 8'hA0));
    vecs.push_back(mk(4'b0011, 0, 0, 1, 0, 4'b0010, 8'hA1));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 8'h00));
`else
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(4'b1111, 0, 0, 1, 0, 4'(1 << (i % 4)), 8'hA0 + 8'(i % 4)));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(4'b0110, 0, 1, 0, 0, 4'b0000, 8'h00));
    vecs.push_back(mk(4'b0110, 0, 0, 1, 0, 4'b0010, 8'hA1));
    vecs.push_back(mk(4'b0110, 0, 0, 1, 0, 4'b0100, 8'hA2));
    vecs.push_back(mk(4'b1000, 0, 0, 1, 0, 4'b1000, 8'hA3));
    vecs.push_back(mk(4'b0001, 0, 0, 1, 0, 4'b0001, 8'hA0));
    vecs.push_back(mk(4'b1000, 0, 0, 1, 0, 4'b1000, 8'hA3));
    vecs.push_back(mk(4'b1001, 0, 0, 1, 0, 4'b0001, 8'hA0));
    vecs.push_back(mk(4'b0001, 1, 0, 1, 0, 4'b0001, 8'hA0));
    vecs.push_back(mk(4'b0001, 1, 0, 0, 1, 4'b0000, 8'h00));
    vecs.push_back(mk(4'b0001, 0, 0, 1, 0, 4'b0001, 8'hA0));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 8'h00));
`endif

    // Reset with every requester valid: nothing may be granted or cleared.
    #12;
    checkVal("reset_w",    {31'd0, fifo_w},     32'd0);
    checkVal("reset_clr",  {31'd0, fifo_clr},   32'd0);
    checkVal("reset_busy", {31'd0, flush_busy}, 32'd0);
    checkVal("reset_rdy",  {28'd0, req_rdy},    32'd0);
    req_vld = 4'b0000;
    @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end

    // Async reset in the middle of the FLUSH cycle, then priority restarts at 0.
    @(negedge clk);
    req_vld = 4'b0001; flush_req = 1'b1; fifo_full = 1'b0;
    #2;
    checkVal("midrst_pre_w", {31'd0, fifo_w}, 32'd1);
    @(negedge clk);
    flush_req = 1'b0;
    #2;
    checkVal("midrst_flush_clr", {31'd0, fifo_clr}, 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    checkVal("midrst_clr",  {31'd0, fifo_clr},   32'd0);
    checkVal("midrst_busy", {31'd0, flush_busy}, 32'd0);
    checkVal("midrst_w",    {31'd0, fifo_w},     32'd0);
    checkVal("midrst_rdy",  {28'd0, req_rdy},    32'd0);
    req_vld = 4'b0000;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    req_vld = 4'b1001;
    #2;
    checkVal("postrst_rdy", {28'd0, req_rdy},  32'h1);
    checkVal("postrst_din", {24'd0, fifo_din}, 32'hA0);

    // Random traffic: structural invariants of the write port.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      req_vld   = 4'($urandom_range(0, 15));
      flush_req = ($urandom_range(0, 7) == 0);
      fifo_full = ($urandom_range(0, 3) == 0);
      #2;
      checkVal($sformatf("rnd%0d_w_clr_excl", i), {31'd0, fifo_w & fifo_clr}, 32'd0);
      checkVal($sformatf("rnd%0d_rdy_vld", i), {28'd0, req_rdy & ~req_vld}, 32'd0);
      checkVal($sformatf("rnd%0d_rdy_onehot", i), {31'd0, $countones(req_rdy) <= 1}, 32'd1);
      checkVal($sformatf("rnd%0d_rdy_w", i), {31'd0, |req_rdy}, {31'd0, fifo_w});
      checkVal($sformatf("rnd%0d_w_full", i), {31'd0, fifo_w & fifo_full}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
